clefia_kat_bist: RTL

Synthesizable known-answer-test sequencer that replaces the hand-written stimulus in our CLEFIA top-level simulation. It drives NUM_VEC plaintext/key vectors into a CLEFIA core and compares every result against the expected ciphertext. It reports pass/fail, the first failing index and an error count, and supports a timeout and a hold-until-valid core handshake. It sits between a vector ROM and the CLEFIA core's din/key/din_valid/dout/dout_valid interface, usable both in simulation and as on-chip BIST.

---
 rtl/clefia_pkg.sv | 27 ++
 rtl/clefia_kat_rom.sv | 46 ++++
 rtl/clefia_kat_bist.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/clefia_pkg.sv
// Shared types and constants for the CLEFIA known-answer-test sequencer.
// Contents: FSM state enum, CLEFIA block/key widths, the "no failure" index
// marker and a saturating 8-bit increment used by the error counter.
package clefia_pkg;

    localparam int unsigned CLEFIA_BLK_W     = 128;
    localparam int unsigned CLEFIA_KEY_W_128 = 128;
    localparam int unsigned CLEFIA_KEY_W_192 = 192;
    localparam int unsigned CLEFIA_KEY_W_256 = 256;

    // fail_idx value while no vector has failed
    localparam logic [7:0] FAIL_IDX_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    // Increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/clefia_kat_rom.sv
// Combinational known-answer vector table for CLEFIA.
// Ports:
//   vec_idx  in   8        vector address
//   vec_pt   out  128      plaintext
//   vec_key  out  KEY_W    key for the configured key size
//   vec_ct   out  128      expected ciphertext
// The published vectors share one plaintext, and the 128/192-bit keys are
// prefixes of the 256-bit key, so the key is a slice of one constant and only
// the ciphertext depends on the mode. Every address returns the published
// vector; repeating it back to back catches state leaking between blocks.
module clefia_kat_rom
    import clefia_pkg::*;
#(
    parameter int unsigned KEY_W = CLEFIA_KEY_W_128
) (
    input  logic [7:0]              vec_idx,
    output logic [CLEFIA_BLK_W-1:0] vec_pt,
    output logic [KEY_W-1:0]        vec_key,
    output logic [CLEFIA_BLK_W-1:0] vec_ct
);

    localparam logic [255:0] KEY_FULL =
        256'hffeeddccbbaa99887766554433221100_f0e0d0c0b0a090807060504030201000;
    localparam logic [127:0] PT_STD = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] CT_128 = 128'hde2bf2fd_9b74aacd_f1298555_459494fd;
    localparam logic [127:0] CT_192 = 128'he2482f64_9f028dc4_80dda184_fde181ad;
    localparam logic [127:0] CT_256 = 128'ha1397814_289de80c_10da46d1_fa48b38a;

    // The address does not select content; reduce it so it is still consumed.
    logic unused_idx;
    assign unused_idx = ^vec_idx;

    assign vec_pt  = PT_STD;
    assign vec_key = KEY_FULL[255 -: KEY_W];

    // Expected ciphertext per key size
    always_comb begin
        vec_ct = CT_128;
        case (KEY_W)
            CLEFIA_KEY_W_192: vec_ct = CT_192;
            CLEFIA_KEY_W_256: vec_ct = CT_256;
            default:          vec_ct = CT_128;
        endcase
    end

endmodule

// File: rtl/clefia_kat_bist.sv
// Known-answer-test sequencer for a CLEFIA core.
// Walks vec_idx through NUM_VEC ROM entries, holds each vector on the core
// with core_din_valid until core_dout_valid or TIMEOUT, compares the result
// against the expected ciphertext and reports pass/error count/first failure.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       pulse; accepted in IDLE or DONE
//   busy, done, pass            status (pass valid while done)
//   err_count                   mismatches + timeouts, saturating
//   fail_idx, fail_timeout      first failing vector and its cause
//   vec_idx / vec_pt/key/ct     ROM address and combinational ROM data
//   core_din/key/din_valid      vector to the core, valid held while in flight
//   core_dout/dout_valid        core result and strobe
module clefia_kat_bist
    import clefia_pkg::*;
#(
    parameter int unsigned NUM_VEC      = 4,
    parameter int unsigned DATA_W       = CLEFIA_BLK_W,
    parameter int unsigned KEY_W        = CLEFIA_KEY_W_128,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned GAP          = 2,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [7:0]        fail_idx,
    output logic              fail_timeout,
    output logic [7:0]        vec_idx,
    input  logic [DATA_W-1:0] vec_pt,
    input  logic [KEY_W-1:0]  vec_key,
    input  logic [DATA_W-1:0] vec_ct,
    output logic [DATA_W-1:0] core_din,
    output logic [KEY_W-1:0]  core_key,
    output logic              core_din_valid,
    input  logic [DATA_W-1:0] core_dout,
    input  logic              core_dout_valid
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    // GAP=0 still spends one cycle in ST_GAP so din_valid is low at least once
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_VEC - 1);

    state_t            state;
    logic [DATA_W-1:0] exp_ct;
    logic [TMR_W-1:0]  timer;
    logic [GAP_W-1:0]  gap_cnt;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            fail_idx       <= FAIL_IDX_NONE;
            fail_timeout   <= 1'b0;
            vec_idx        <= 8'd0;
            core_din       <= '0;
            core_key       <= '0;
            core_din_valid <= 1'b0;
            exp_ct         <= '0;
            timer          <= '0;
            gap_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        vec_idx      <= 8'd0;
                        err_count    <= 8'd0;
                        fail_idx     <= FAIL_IDX_NONE;
                        fail_timeout <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    core_din       <= vec_pt;
                    core_key       <= vec_key;
                    exp_ct         <= vec_ct;
                    core_din_valid <= 1'b1;
                    timer          <= '0;
                    state          <= ST_RUN;
                end

                ST_RUN: begin
                    // A strobe on the timeout cycle takes priority over the timeout
                    if (core_dout_valid || (timer == TMR_LAST)) begin
                        if (!core_dout_valid || (core_dout != exp_ct)) begin
                            err_count <= sat_inc8(err_count);
                            if (err_count == 8'd0) begin
                                fail_idx     <= vec_idx;
                                fail_timeout <= ~core_dout_valid;
                            end
                        end
                        core_din_valid <= 1'b0;
                        core_din       <= '0;
                        core_key       <= '0;
                        gap_cnt        <= '0;
                        state          <= ST_GAP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if ((vec_idx == LAST_IDX) ||
                            ((STOP_ON_FAIL != 0) && (err_count != 8'd0))) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 8'd0);
                        end else begin
                            vec_idx <= vec_idx + 8'd1;
                            state   <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
